// File: rtl/grant_tenure_if.sv
// Bus between the round-queue arbiter side and grant_tenure_ctrl.
// The arbiter/stimulus side uses the master modport and the controller uses the slave modport.
interface grant_tenure_if #(
    parameter int CNT_W = 8
);
    logic [3:0]       grant_i;
    logic [3:0]       done_i;
    logic [1:0]       cnt_sel_i;
    logic [3:0]       bus_owner_o;
    logic [1:0]       owner_id_o;
    logic             busy_o;
    logic             timeout_o;
    logic             drop_o;
    logic             onehot_err_o;
    logic [CNT_W-1:0] cnt_o;

    modport master (
        output grant_i, done_i, cnt_sel_i,
        input  bus_owner_o, owner_id_o, busy_o, timeout_o, drop_o, onehot_err_o, cnt_o
    );

    modport slave (
        input  grant_i, done_i, cnt_sel_i,
        output bus_owner_o, owner_id_o, busy_o, timeout_o, drop_o, onehot_err_o, cnt_o
    );
endinterface

// File: rtl/grant_tenure_ctrl.sv
// Turns one-hot arbiter grant events into exclusive, time-bounded ownership of a shared resource.
// Define GRANT_TENURE_STATS_EN to build the per-user accepted-grant counters behind cnt_o.
module grant_tenure_ctrl #(
    parameter int TENURE_MAX = 8,
    parameter int CNT_W      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    grant_tenure_if.slave bus
);
    localparam int TW = $clog2(TENURE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OWNED   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_nxt;
    logic [3:0]    grant_q;
    logic [3:0]    owner_q, owner_nxt;
    logic [1:0]    id_q, id_nxt;
    logic          busy_q, busy_nxt;
    logic          timeout_q, timeout_nxt;
    logic          drop_q, drop_nxt;
    logic          err_q, err_nxt;
    logic [TW-1:0] count_q, count_nxt;
    logic          event_c, onehot_c, valid_c, accept_c;

    // Grant vector bit 3 is user1, so user index 0 sits in the MSB.
    function automatic logic [1:0] enc_user(input logic [3:0] g);
        case (g)
            4'b1000: enc_user = 2'd0;
            4'b0100: enc_user = 2'd1;
            4'b0010: enc_user = 2'd2;
            default: enc_user = 2'd3;
        endcase
    endfunction

    function automatic logic is_onehot(input logic [3:0] g);
        is_onehot = (g != 4'b0000) && ((g & (g - 4'd1)) == 4'b0000);
    endfunction

    assign event_c  = (bus.grant_i != grant_q) && (bus.grant_i != 4'b0000);
    assign onehot_c = is_onehot(bus.grant_i);
    assign valid_c  = event_c && onehot_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            id_q      <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_nxt;
            grant_q   <= bus.grant_i;
            owner_q   <= owner_nxt;
            id_q      <= id_nxt;
            busy_q    <= busy_nxt;
            timeout_q <= timeout_nxt;
            drop_q    <= drop_nxt;
            err_q     <= err_nxt;
            count_q   <= count_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        owner_nxt   = owner_q;
        id_nxt      = id_q;
        busy_nxt    = busy_q;
        count_nxt   = count_q;
        timeout_nxt = 1'b0;
        drop_nxt    = 1'b0;
        err_nxt     = event_c && !onehot_c;
        accept_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_c) begin
                    state_nxt = OWNED;
                    owner_nxt = bus.grant_i;
                    id_nxt    = enc_user(bus.grant_i);
                    busy_nxt  = 1'b1;
                    count_nxt = TW'(1);
                    accept_c  = 1'b1;
                end
            end
            OWNED: begin
                drop_nxt = valid_c;
                // A done from the owner takes priority over an expiring tenure.
                if ((bus.done_i & owner_q) != 4'b0000) begin
                    state_nxt = RELEASE;
                    owner_nxt = '0;
                    id_nxt    = '0;
                    busy_nxt  = 1'b0;
                    count_nxt = '0;
                end else if (count_q == TW'(TENURE_MAX)) begin
                    state_nxt   = RELEASE;
                    owner_nxt   = '0;
                    id_nxt      = '0;
                    busy_nxt    = 1'b0;
                    count_nxt   = '0;
                    timeout_nxt = 1'b1;
                end else begin
                    count_nxt = count_q + TW'(1);
                end
            end
            RELEASE: begin
                drop_nxt  = valid_c;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                owner_nxt = '0;
                id_nxt    = '0;
                busy_nxt  = 1'b0;
                count_nxt = '0;
            end
        endcase
    end

    assign bus.bus_owner_o  = owner_q;
    assign bus.owner_id_o   = id_q;
    assign bus.busy_o       = busy_q;
    assign bus.timeout_o    = timeout_q;
    assign bus.drop_o       = drop_q;
    assign bus.onehot_err_o = err_q;

`ifdef GRANT_TENURE_STATS_EN
    logic [CNT_W-1:0] stats_q [4];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) stats_q[i] <= '0;
        end else if (accept_c) begin
            stats_q[enc_user(bus.grant_i)] <= sat_inc(stats_q[enc_user(bus.grant_i)]);
        end
    end

    assign bus.cnt_o = stats_q[bus.cnt_sel_i];
`else
    logic unused_sel;
    logic unused_accept;
    assign unused_sel    = ^bus.cnt_sel_i;
    assign unused_accept = accept_c;
    assign bus.cnt_o     = '0;
`endif
endmodule
